spi_master_ctrl: RTL and testbench

- Single-clock SPI master. Serializes memory commands (write-address, write-data, read-address, read-data) onto MOSI/SS_n for the SPI-slave memory wrapper, and deserializes read data returned on MISO.
- Replaces the bench-driven bit-banging of the slave protocol, and lets a system-side controller access the SPI RAM through a simple start/done handshake.

---
 rtl/spi_master_ctrl.sv | 142 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master serializing 11-bit memory command frames, capturing read data on MISO
// Frame = {cmd[1], cmd, tx_data}, MSB first; rd-data frames append an 8-bit capture window.
module spi_master_ctrl #(
    parameter int RX_START   = 11,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    input  logic       MISO,
    output logic       MOSI,
    output logic       SS_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam int CNT_W = $clog2(RX_START + GAP_CYCLES + 9);
    localparam logic [CNT_W-1:0] LAST_TX  = CNT_W'(10);
    localparam logic [CNT_W-1:0] CAP_FRST = CNT_W'(RX_START);
    localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(RX_START + 7);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      shift_q, shift_d;
    logic             rd_q, rd_d;
    logic             mosi_q, mosi_d;
    logic             ss_n_q, ss_n_d;
    logic             done_q, done_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [10:0]      frame;

    assign frame = {cmd[1], cmd, tx_data};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rd_d       = rd_q;
        mosi_d     = 1'b0;
        ss_n_d     = 1'b1;
        done_d     = 1'b0;
        rx_valid_d = 1'b0;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Bit 10 goes straight to MOSI; the remainder waits in the shifter.
                    mosi_d  = frame[10];
                    shift_d = {frame[9:0], 1'b0};
                    rd_d    = (cmd == 2'b11);
                    ss_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_TX) begin
                    if (rd_q) begin
                        ss_n_d  = 1'b0;
                        state_d = RECV;
                    end else begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = GAP;
                    end
                end else begin
                    ss_n_d  = 1'b0;
                    mosi_d  = shift_q[10];
                    shift_d = {shift_q[9:0], 1'b0};
                end
            end
            RECV: begin
                cnt_d  = cnt_q + 1'b1;
                ss_n_d = 1'b0;
                if (cnt_q >= CAP_FRST) begin
                    rx_sh_d = {rx_sh_q[6:0], MISO};
                end
                if (cnt_q == CAP_LAST) begin
                    rx_data_d  = {rx_sh_q[6:0], MISO};
                    rx_valid_d = 1'b1;
                    done_d     = 1'b1;
                    ss_n_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rd_q       <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rd_q       <= rd_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign MOSI     = mosi_q;
    assign SS_n     = ss_n_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - randomized scoreboard bench for spi_master_ctrl with a behavioural SPI memory slave
module tb_spi_master_ctrl;

    localparam int RX_START   = 11;
    localparam int GAP_CYCLES = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       MISO = 1'b0;
    logic       MOSI, SS_n, busy, done, rx_valid;
    logic [7:0] rx_data;

    spi_master_ctrl #(.RX_START(RX_START), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .tx_data(tx_data),
        .MISO(MISO), .MOSI(MOSI), .SS_n(SS_n), .busy(busy), .done(done),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [1:0] cmd;
        logic [7:0] tx;
    } req_t;

    req_t fq[$];
    req_t rq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_waddr = 0, ref_raddr = 0, last_rx = 0;
    logic [7:0] s_mem [256];
    logic [7:0] s_waddr = 0, s_raddr = 0, s_rd = 0;
    logic [10:0] s_bits = 0;
    int   s_cnt = 0;

    always @(posedge clk) cyc++;

    function automatic int flen(input logic [1:0] c);
        return (c == 2'b11) ? RX_START + 8 : 11;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural SPI memory slave: decodes the frame from MOSI, drives MISO in the capture window.
    always @(negedge clk) begin : slave
        int k;
        if (SS_n) begin
            s_cnt = 0;
            MISO  = 1'($urandom);
        end else begin
            k = s_cnt;
            s_cnt++;
            if (k < 11) s_bits = {s_bits[9:0], MOSI};
            if (k == 10) begin
                case (s_bits[9:8])
                    2'b00: s_waddr = s_bits[7:0];
                    2'b01: s_mem[s_waddr] = s_bits[7:0];
                    2'b10: s_raddr = s_bits[7:0];
                    default: s_rd = s_mem[s_raddr];
                endcase
            end
            if (k >= RX_START && k < RX_START + 8) MISO = s_rd[7 - (k - RX_START)];
            else MISO = 1'($urandom);
        end
    end

    // Monitor: timeline expectations from the head request, result scoreboard popped on done.
    always @(negedge clk) begin : monitor
        int          k, len;
        logic [10:0] frame;
        logic        e_ss, e_mosi, e_busy, e_done, e_rv, pop_f;
        req_t        f, r;
        if (mon_en) begin
            e_ss = 1; e_mosi = 0; e_busy = 0; e_done = 0; e_rv = 0; pop_f = 0;
            if (fq.size() > 0) begin
                f     = fq[0];
                k     = cyc - f.c - 1;
                len   = flen(f.cmd);
                frame = {f.cmd[1], f.cmd, f.tx};
                if (k >= 0 && k < len) e_ss = 0;
                if (k >= 0 && k < 11) e_mosi = frame[10 - k];
                if (k >= 0 && k < len + GAP_CYCLES) e_busy = 1;
                if (k == len) begin
                    e_done = 1;
                    e_rv   = (f.cmd == 2'b11);
                end
                if (k == len + GAP_CYCLES - 1) pop_f = 1;
            end
            chk("ss_n", SS_n, e_ss);
            chk("mosi", MOSI, e_mosi);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("rx_valid", rx_valid, e_rv);
            if (done) begin
                if (rq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    r = rq.pop_front();
                    case (r.cmd)
                        2'b00: ref_waddr = r.tx;
                        2'b01: ref_mem[ref_waddr] = r.tx;
                        2'b10: ref_raddr = r.tx;
                        default: last_rx = ref_mem[ref_raddr];
                    endcase
                    chk("rx_valid_cmd", rx_valid, (r.cmd == 2'b11));
                end
            end
            chk("rx_data", rx_data, last_rx);
            if (pop_f) void'(fq.pop_front());
        end
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] d);
        req_t r;
        r.c = cyc; r.cmd = c; r.tx = d;
        fq.push_back(r);
        rq.push_back(r);
        start = 1; cmd = c; tx_data = d;
        @(posedge clk) #1;
        start = 0; cmd = 2'($urandom); tx_data = 8'($urandom);
    endtask

    task automatic go(input logic [1:0] c, input logic [7:0] d, input int idle);
        issue(c, d);
        repeat (flen(c) + GAP_CYCLES + idle) @(posedge clk) #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 0;
            s_mem[i]   = 0;
        end
        rst_n = 0; start = 0; cmd = 0; tx_data = 0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1;
        @(posedge clk) #1;
        rst_n = 1;
        repeat (2) @(posedge clk) #1;

        go(2'b00, 8'h64, 0);
        go(2'b01, 8'h0B, 0);
        go(2'b10, 8'h64, 0);
        go(2'b11, 8'($urandom), 2);

        // start during a frame must be ignored
        issue(2'b01, 8'h16);
        repeat (5) @(posedge clk) #1;
        start = 1; cmd = 2'b00; tx_data = 8'hFF;
        @(posedge clk) #1;
        start = 0;
        repeat (flen(2'b01) + GAP_CYCLES - 6) @(posedge clk) #1;

        // abort a wr-data frame at cycle 6; rx_data must clear
        issue(2'b01, 8'hA5);
        repeat (6) @(posedge clk) #1;
        rst_n = 0;
        @(posedge clk) #1;
        rst_n = 1;
        fq.delete();
        rq.delete();
        last_rx = 0;
        repeat (2) @(posedge clk) #1;
        go(2'b11, 8'h00, 0);

        for (int i = 0; i < 20; i++) go(2'(i % 2), 8'($urandom), 0);

        for (int i = 0; i < 100; i++) begin
            go(2'b00, 8'(100 + i), 0);
            go(2'b01, 8'(11 * ((i % 23) + 1)), 0);
        end
        for (int i = 0; i < 100; i++) begin
            go(2'b10, 8'(100 + i), 0);
            go(2'b11, 8'($urandom), 0);
        end

        for (int i = 0; i < 200; i++)
            go(2'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

        repeat (5) @(posedge clk) #1;
        chk("timeline_drained", fq.size(), 0);
        chk("scoreboard_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
